ground_scroll_ctrl: RTL and testbench

Sequencer for the ground strip of the playfield: owns the per-frame horizontal scroll of the ground texture, detects the bird landing on the ground, and freezes the scroll when the round ends. Sits between the game-state logic and the pixel mux. Consumes the VGA pixel coordinates and a frame-start pulse. Produces a registered ground-region flag, a scrolled stripe texture bit, and a one-cycle ground-hit event.

---
 rtl/ground_scroll_ctrl.sv | 107 ++++++++++
 tb/tb_ground_scroll_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ground_scroll_ctrl.sv
// Ground strip sequencer: scroll offset, band flag, stripe texture and ground-hit event.
// Latency 1 cycle, no backpressure; stripe texture is built only with GROUND_STRIPE_EN defined.
module ground_scroll_ctrl #(
  parameter int GROUND_TOP = 465,
  parameter int GROUND_BOT = 479,
  parameter int SCROLL_W   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                frame_tick,
  input  logic                start,
  input  logic                ext_hit,
  input  logic [9:0]          bird_bottom,
  input  logic [2:0]          speed,
  output logic                ground_on,
  output logic                ground_stripe,
  output logic                ground_hit,
  output logic [SCROLL_W-1:0] scroll,
  output logic                running,
  output logic                halted
);

  localparam logic [9:0] TOP = 10'(GROUND_TOP);
  localparam logic [9:0] BOT = 10'(GROUND_BOT);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                state, state_nxt;
  logic [SCROLL_W-1:0]   scroll_nxt;
  logic                  hit_nxt;
  logic                  in_band;
  logic                  stripe_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      scroll     <= '0;
      ground_hit <= 1'b0;
    end else begin
      state      <= state_nxt;
      scroll     <= scroll_nxt;
      ground_hit <= hit_nxt;
    end
  end

  // A ground landing outranks a pipe collision, and any hit suppresses that frame's advance.
  always_comb begin
    state_nxt  = state;
    scroll_nxt = scroll;
    hit_nxt    = 1'b0;
    case (state)
      IDLE: begin
        scroll_nxt = '0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (bird_bottom >= TOP) begin
          hit_nxt   = 1'b1;
          state_nxt = HALT;
        end else if (ext_hit) begin
          state_nxt = HALT;
        end else if (frame_tick) begin
          scroll_nxt = scroll + SCROLL_W'(speed);
        end
      end
      HALT: begin
        if (start) begin
          state_nxt  = IDLE;
          scroll_nxt = '0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        scroll_nxt = '0;
      end
    endcase
  end

  assign in_band = (y >= TOP) && (y <= BOT);

`ifdef GROUND_STRIPE_EN
  logic [9:0] stripe_sum;
  // Row offset makes the stripes diagonal; it is only meaningful inside the band.
  assign stripe_sum = x + 10'(scroll) + (y - TOP);
  assign stripe_bit = in_band & stripe_sum[3];
`else
  logic unused_x;
  assign unused_x   = ^x;
  assign stripe_bit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ground_on     <= 1'b0;
      ground_stripe <= 1'b0;
    end else begin
      ground_on     <= in_band;
      ground_stripe <= stripe_bit;
    end
  end

  assign running = (state == RUN);
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// Directed scoreboard bench for ground_scroll_ctrl; stripe expectations follow GROUND_STRIPE_EN.
module tb_ground_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x, y, bird_bottom;
  logic       frame_tick, start, ext_hit;
  logic [2:0] speed;
  logic       ground_on, ground_stripe, ground_hit, running, halted;
  logic [4:0] scroll;

  always #5 clk = ~clk;

  ground_scroll_ctrl dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
    .start(start), .ext_hit(ext_hit), .bird_bottom(bird_bottom), .speed(speed),
    .ground_on(ground_on), .ground_stripe(ground_stripe), .ground_hit(ground_hit),
    .scroll(scroll), .running(running), .halted(halted)
  );

  typedef struct packed {
    logic       on;
    logic       stripe;
    logic       hit;
    logic       run;
    logic       halt;
    logic [4:0] scroll;
  } obs_t;

  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;

  obs_t    exp_q[$];
  string   tag_q[$];
  int      checks = 0;
  int      errors = 0;
  mstate_t ms;
  logic [4:0] mscroll;

  function automatic obs_t sample();
    obs_t o;
    o.on = ground_on; o.stripe = ground_stripe; o.hit = ground_hit;
    o.run = running;  o.halt = halted;          o.scroll = scroll;
    return o;
  endfunction

  task automatic check_obs();
    obs_t  e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = sample();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed on/stripe/hit/run/halt/scroll=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
             t, o.on, o.stripe, o.hit, o.run, o.halt, o.scroll,
             e.on, e.stripe, e.hit, e.run, e.halt, e.scroll);
    end
  endtask

  task automatic push_zero(input string tg);
    obs_t e;
    e = '0;
    exp_q.push_back(e);
    tag_q.push_back(tg);
  endtask

  task automatic chk_scroll(input logic [4:0] v, input string tg);
    checks++;
    assert (scroll === v) else begin
      errors++;
      $error("FAIL %s: observed scroll=%0d expected %0d", tg, scroll, v);
    end
  endtask

  // One clock: drive at negedge, predict, push; compare 1 ns after the sampling edge.
  task automatic step(input logic [9:0] px, input logic [9:0] py, input logic pt,
                      input logic ps, input logic pe, input logic [9:0] pb,
                      input logic [2:0] sp, input string tg);
    obs_t       e;
    logic       inb;
    logic [9:0] sum;
    @(negedge clk);
    x = px; y = py; frame_tick = pt; start = ps; ext_hit = pe; bird_bottom = pb; speed = sp;
    inb = (py >= 10'd465) && (py <= 10'd479);
    sum = px + {5'b0, mscroll} + (py - 10'd465);
    e = '0;
    e.on = inb;
`ifdef GROUND_STRIPE_EN
    e.stripe = inb & sum[3];
`else
    e.stripe = 1'b0;
`endif
    case (ms)
      M_IDLE: if (ps) ms = M_RUN;
      M_RUN: begin
        if (pb >= 10'd465) begin
          e.hit = 1'b1;
          ms = M_HALT;
        end else if (pe) begin
          ms = M_HALT;
        end else if (pt) begin
          mscroll = mscroll + {2'b0, sp};
        end
      end
      default: if (ps) begin
        ms = M_IDLE;
        mscroll = '0;
      end
    endcase
    e.run = (ms == M_RUN);
    e.halt = (ms == M_HALT);
    e.scroll = mscroll;
    exp_q.push_back(e);
    tag_q.push_back(tg);
    @(posedge clk);
    #1;
    check_obs();
  endtask

  initial begin
    ms = M_IDLE; mscroll = '0;
    reset_n = 1'b0;
    x = '0; y = '0; frame_tick = 0; start = 0; ext_hit = 0; bird_bottom = '0; speed = '0;
    #3;
    push_zero("reset_state");
    check_obs();
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE: band edges, and tick/ext_hit/bird_bottom ignored
    step(0, 464, 1, 0, 1, 470, 7, "idle_y464");
    step(0, 465, 1, 0, 0, 470, 7, "idle_y465");
    step(8, 479, 0, 0, 1, 0, 7,   "idle_y479");
    step(8, 480, 1, 0, 0, 0, 7,   "idle_y480");

    // RUN: speed 7 wrap sequence, start ignored
    step(0, 465, 0, 1, 0, 100, 7, "start_run");
    step(3, 464, 1, 1, 0, 100, 7, "tick1");  chk_scroll(5'd7,  "scroll_7");
    step(5, 465, 1, 0, 0, 100, 7, "tick2");  chk_scroll(5'd14, "scroll_14");
    step(9, 470, 1, 1, 0, 100, 7, "tick3");  chk_scroll(5'd21, "scroll_21");
    step(2, 479, 1, 0, 0, 100, 7, "tick4");  chk_scroll(5'd28, "scroll_28");
    step(1, 480, 1, 0, 0, 100, 7, "tick5");  chk_scroll(5'd3,  "scroll_wrap_3");
    step(0, 470, 1, 0, 0, 100, 0, "speed0_a");
    step(0, 470, 1, 0, 0, 100, 0, "speed0_b"); chk_scroll(5'd3, "scroll_speed0");
    for (int i = 0; i < 3; i++) step(10'(i * 4), 466, 1, 0, 0, 200, 3, "tick_speed3");
    chk_scroll(5'd12, "scroll_12");

    // ext_hit with frame_tick: halt, no advance, no ground_hit
    step(0, 470, 1, 0, 1, 200, 3, "ext_hit_tick");
    chk_scroll(5'd12, "ext_hit_frozen");
    for (int i = 0; i < 3; i++) step(0, 470, 1, 0, 0, 470, 3, "halt_frozen");
    step(0, 464, 0, 0, 0, 0, 0, "halt_y464");
    step(0, 480, 0, 0, 0, 0, 0, "halt_y480");

    // Restart: HALT -> IDLE (scroll 0) -> RUN
    step(0, 0, 0, 1, 0, 0, 0, "halt_start_idle");
    step(0, 0, 1, 0, 0, 0, 5, "idle_tick");
    step(0, 0, 0, 1, 0, 0, 0, "idle_start_run");

    // Ground hit boundary, one-cycle pulse, frozen scroll
    step(0, 0, 1, 0, 0, 100, 5, "run_tick");
    step(0, 0, 0, 0, 0, 464, 5, "bb464_nohit");
    step(0, 0, 1, 0, 0, 465, 5, "bb465_hit");
    step(0, 0, 0, 0, 0, 465, 5, "hit_pulse_end");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 5, "hit_frozen");

    // ext_hit together with landing: ground_hit still fires
    step(0, 0, 0, 1, 0, 0, 0, "restart_idle");
    step(0, 0, 0, 1, 0, 0, 0, "restart_run");
    step(0, 0, 0, 0, 1, 470, 0, "both_hit");

    // Reset mid-RUN at scroll=20
    step(0, 0, 0, 1, 0, 0, 0, "r_idle");
    step(0, 470, 0, 1, 0, 0, 0, "r_run");
    for (int i = 0; i < 5; i++) step(0, 470, 1, 0, 0, 0, 4, "tick_speed4");
    chk_scroll(5'd20, "scroll_20");
    #2;
    reset_n = 1'b0;
    ms = M_IDLE; mscroll = '0;
    #1;
    push_zero("async_reset");
    check_obs();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 470, 1, 0, 0, 470, 4, "post_reset_idle");

    // Stripe at the top row with scroll=0
    step(0, 465, 0, 0, 0, 0, 0, "stripe_x0");
    step(8, 465, 0, 0, 0, 0, 0, "stripe_x8");
`ifdef GROUND_STRIPE_EN
    chk_scroll(5'd0, "stripe_scroll0");
    checks++;
    assert (ground_stripe === 1'b1) else begin
      errors++;
      $error("FAIL stripe_x8_direct: observed %b expected 1", ground_stripe);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
